// File: rtl/eaglesong_pkg.sv
// Shared constants, FSM encoding and the 32-bit rotate used by the
// Eaglesong circulant-multiplication step.
package eaglesong_pkg;

  localparam int NUM_WORDS  = 16;
  localparam int TERMS      = 3;
  localparam int WORD_W     = 32;
  localparam int COEF_W     = 5;
  localparam int IDX_W      = 6;
  localparam int WORD_CNT_W = 5;
  localparam int TERM_CNT_W = 2;
  localparam int STATE_W    = NUM_WORDS * WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } step_state_e;

  // Rotating a doubled word keeps r=0 legal without a 32-bit shift.
  function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] x,
                                               input logic [COEF_W-1:0] r);
    logic [2*WORD_W-1:0] dbl;
    dbl = {x, x} << r;
    return dbl[2*WORD_W-1:WORD_W];
  endfunction

endpackage

// File: rtl/eaglesong_rotl32.sv
// Combinational 32-bit left rotator with a 5-bit rotate amount.
module eaglesong_rotl32
  import eaglesong_pkg::*;
(
  input  logic [WORD_W-1:0] i_x,
  input  logic [COEF_W-1:0] i_r,
  output logic [WORD_W-1:0] o_y
);

  assign o_y = rotl32(i_x, i_r);

endmodule

// File: rtl/eaglesong_circulant_step.sv
// Eaglesong circulant step: out[i] = XOR_j rotl(in[i], c[3i+j]), one
// (word, term) pair per clock using an external coefficient ROM.
module eaglesong_circulant_step
  import eaglesong_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [STATE_W-1:0] state_in,
  output logic [IDX_W-1:0]   coef_index,
  input  logic [COEF_W-1:0]  coef_value,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] state_out
);

  step_state_e r_state;
  step_state_e w_state_next;

  logic [NUM_WORDS-1:0][WORD_W-1:0] r_work;
  logic [NUM_WORDS-1:0][WORD_W-1:0] r_state_out;
  logic [NUM_WORDS-1:0][WORD_W-1:0] w_work_next;
  logic [WORD_CNT_W-1:0]            r_word;
  logic [TERM_CNT_W-1:0]            r_term;
  logic [WORD_W-1:0]                r_acc;

  logic [WORD_W-1:0] w_cur_word;
  logic [WORD_W-1:0] w_rot;
  logic [WORD_W-1:0] w_acc_next;
  logic              w_word_valid;
  logic              w_last_term;
  logic              w_last_word;
  logic [IDX_W:0]    w_idx_full;

  assign w_word_valid = ~r_word[WORD_CNT_W-1];
  assign w_last_term  = (r_term >= 2'd2);
  assign w_last_word  = (r_word == 5'd15);
  assign w_cur_word   = r_work[r_word[3:0]];
  assign w_acc_next   = r_acc ^ w_rot;

  eaglesong_rotl32 u_rotl (
    .i_x (w_cur_word),
    .i_r (coef_value),
    .o_y (w_rot)
  );

  // NOTE: every always_comb output gets a full default first so no latch is inferred.
  always_comb begin
    w_work_next = r_work;
    if (w_last_term) w_work_next[r_word[3:0]] = w_acc_next;
  end

  assign w_idx_full = {2'b00, r_word} * 7'd3 + {5'b00000, r_term};
  assign coef_index = (r_state == ST_RUN) ? w_idx_full[IDX_W-1:0] : '0;
  assign busy       = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign done       = (r_state == ST_DONE);
  assign state_out  = r_state_out;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN: begin
        if (!w_word_valid)                   w_state_next = ST_IDLE;
        else if (w_last_term && w_last_word) w_state_next = ST_DONE;
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: the work array is reset too, so an aborted run leaves no stale data behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work      <= '0;
      r_state_out <= '0;
      r_word      <= '0;
      r_term      <= '0;
      r_acc       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_work <= state_in;
            r_word <= '0;
            r_term <= '0;
            r_acc  <= '0;
          end
        end
        ST_RUN: begin
          if (w_word_valid) begin
            if (!w_last_term) begin
              r_acc  <= w_acc_next;
              r_term <= r_term + 2'd1;
            end else begin
              // All three reads of this word are done, so in-place write-back is safe.
              r_work <= w_work_next;
              r_acc  <= '0;
              r_term <= '0;
              r_word <= r_word + 5'd1;
              if (w_last_word) r_state_out <= w_work_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eaglesong_circulant_step.sv
// Self-checking bench for eaglesong_circulant_step with a behavioural ROM
// and a word-level reference model of the circulant step.
module tb_eaglesong_circulant_step;

  localparam int ROM_TBL [48] = '{
    0, 2, 4,   0, 13, 22,  0, 4, 19,  0, 3, 14,
    0, 27, 31, 0, 3, 8,    0, 17, 26, 0, 3, 12,
    0, 18, 22, 0, 12, 18,  0, 4, 7,   0, 4, 31,
    0, 12, 27, 0, 7, 17,   0, 7, 8,   0, 1, 13
  };

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [511:0] state_in;
  logic [5:0]   coef_index;
  logic [4:0]   coef_value;
  logic         busy;
  logic         done;
  logic [511:0] state_out;

  logic [4:0] rom [64];

  int n_checks;
  int n_fail;

  eaglesong_circulant_step dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .state_in   (state_in),
    .coef_index (coef_index),
    .coef_value (coef_value),
    .busy       (busy),
    .done       (done),
    .state_out  (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign coef_value = rom[coef_index];

  typedef struct {
    string        name;
    logic [511:0] st_in;
    logic [511:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_rotl(input logic [31:0] x, input int r);
    if (r == 0) return x;
    return (x << r) | (x >> (32 - r));
  endfunction

  function automatic logic [511:0] ref_step(input logic [511:0] s);
    logic [511:0] res;
    logic [31:0]  w;
    logic [31:0]  acc;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      w   = s[32*i +: 32];
      acc = '0;
      for (int j = 0; j < 3; j++) acc ^= ref_rotl(w, ROM_TBL[3*i+j]);
      res[32*i +: 32] = acc;
    end
    return res;
  endfunction

  // One full operation from an idle DUT; checks timing, index sweep and result.
  task automatic do_op(input string name, input logic [511:0] s, input logic [511:0] exp);
    int done_cyc;
    int done_cnt;
    int idx_bad;
    int busy_bad;
    done_cyc = -1;
    done_cnt = 0;
    idx_bad  = 0;
    busy_bad = 0;
    @(negedge clk);
    state_in = s;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    state_in = ~s;
    for (int k = 1; k <= 55; k++) begin
      if (k > 1) @(negedge clk);
      if (busy !== (k <= 49)) busy_bad++;
      if (coef_index !== ((k <= 48) ? 6'(k - 1) : 6'd0)) idx_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (k == 49) check({name, "_result"}, state_out, exp);
    end
    check({name, "_done_cycle"}, 512'(done_cyc), 512'd49);
    check({name, "_done_count"}, 512'(done_cnt), 512'd1);
    check({name, "_busy"}, 512'(busy_bad), 512'd0);
    check({name, "_index_sweep"}, 512'(idx_bad), 512'd0);
    check({name, "_held"}, state_out, exp);
  endtask

  initial begin
    logic [511:0] s;
    logic [511:0] prev;
    int           done_cnt;
    int           busy_bad;

    for (int i = 0; i < 64; i++) rom[i] = 5'd0;
    for (int i = 0; i < 48; i++) rom[i] = 5'(ROM_TBL[i]);
    n_checks = 0;
    n_fail   = 0;
    start    = 1'b0;
    state_in = '0;
    rst_n    = 1'b0;

    vecs[0].name = "zero";
    vecs[0].st_in = '0;
    vecs[0].exp   = '0;
    vecs[1].name = "word0_one";
    vecs[1].st_in = '0;
    vecs[1].st_in[31:0] = 32'h0000_0001;
    vecs[1].exp   = '0;
    vecs[1].exp[31:0]   = 32'h0000_0015;
    vecs[2].name = "word1_word4";
    vecs[2].st_in = '0;
    vecs[2].st_in[63:32]   = 32'h8000_0000;
    vecs[2].st_in[159:128] = 32'h0000_0001;
    vecs[2].exp   = '0;
    vecs[2].exp[63:32]     = 32'h8020_1000;
    vecs[2].exp[159:128]   = 32'h8800_0001;
    vecs[3].name = "word15_ones";
    vecs[3].st_in = '0;
    vecs[3].st_in[511:480] = 32'hFFFF_FFFF;
    vecs[3].exp   = '0;
    vecs[3].exp[511:480]   = 32'hFFFF_FFFF;

    repeat (3) @(negedge clk);
    check("reset_state_out", state_out, '0);
    check("reset_done", 512'(done), 512'd0);
    check("reset_busy", 512'(busy), 512'd0);
    check("reset_coef_index", 512'(coef_index), 512'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) do_op(vecs[v].name, vecs[v].st_in, vecs[v].exp);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom;
      do_op($sformatf("rand%0d", r), s, ref_step(s));
    end

    // start pulses in RUN (cycle 5) and in DONE (cycle 49) must be ignored.
    for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom;
    prev      = ref_step(s);
    done_cnt  = 0;
    busy_bad  = 0;
    @(negedge clk);
    state_in = s;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge clk);
      start = (k == 5) || (k == 49);
      if (k == 5 || k == 49) state_in = ~s;
      if (done === 1'b1) done_cnt++;
      if (k == 49) check("ignore_start_done_at_49", 512'(done), 512'd1);
      if (k >= 50 && busy !== 1'b0) busy_bad++;
    end
    start = 1'b0;
    check("ignore_start_result", state_out, prev);
    check("ignore_start_done_count", 512'(done_cnt), 512'd1);
    check("ignore_start_idle_after", 512'(busy_bad), 512'd0);

    // Asynchronous reset in the middle of RUN aborts with no done pulse.
    for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom;
    done_cnt = 0;
    @(negedge clk);
    state_in = s;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_state_out", state_out, '0);
    check("abort_busy", 512'(busy), 512'd0);
    check("abort_coef_index", 512'(coef_index), 512'd0);
    check("abort_done", 512'(done), 512'd0);
    check("abort_no_done_before", 512'(done_cnt), 512'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after_abort", s, ref_step(s));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
